// File: rtl/gray_histogram_if.sv
// gray_histogram_if
//   Groups the pixel stream, frame control pulses, bin read port and status
//   flags of the gray_histogram block.
//   master : upstream pixel source / readout logic (drives pixels, pulses, reads)
//   slave  : the histogram block itself
//   Ports carried:
//     pix_in[7:0], pix_valid             gray pixel stream (bin index)
//     frame_start, frame_end, hist_clr   single-cycle control pulses
//     rd_en, rd_addr[7:0]                bin read request
//     rd_data[CNT_W-1:0], rd_valid       bin read response (1-cycle latency)
//     busy, hist_ready, sat, missed      status
interface gray_histogram_if #(
    parameter int CNT_W = 20
);
    logic [7:0]       pix_in;
    logic             pix_valid;
    logic             frame_start;
    logic             frame_end;
    logic             hist_clr;
    logic             rd_en;
    logic [7:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             hist_ready;
    logic             sat;
    logic             missed;

    modport master (
        output pix_in, pix_valid, frame_start, frame_end, hist_clr, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, hist_ready, sat, missed
    );

    modport slave (
        input  pix_in, pix_valid, frame_start, frame_end, hist_clr, rd_en, rd_addr,
        output rd_data, rd_valid, busy, hist_ready, sat, missed
    );
endinterface

// File: rtl/gray_histogram.sv
// gray_histogram
//   256-bin luminance histogram of one frame of 8-bit gray pixels. Bins are
//   held in an internal 256 x CNT_W memory, updated by a 2-stage
//   read-modify-write pipeline with same-bin forwarding, and read out through
//   a synchronous port once the frame is complete.
//   Ports:
//     clk        rising-edge system clock
//     rst        asynchronous active-low reset (enters CLEAR)
//     bus        gray_histogram_if.slave (pixels, pulses, read port, status)
//     state_dbg  current FSM state encoding (CLEAR=0 IDLE=1 ACCUM=2 DRAIN=3 DONE=4)
//
//   Handshake semantics: both the pixel stream and the read port are
//   valid-only with no backpressure. A pixel is consumed in any cycle where
//   pix_valid is high and the FSM accepts pixels; a read is consumed in any
//   DONE cycle with rd_en high and answered exactly one cycle later with
//   rd_valid=1. Nothing ever stalls.
module gray_histogram #(
    parameter int CNT_W = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_histogram_if.slave        bus,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [7:0]       clr_cnt;
    logic             drain_cnt;
    logic             pix_acc;
    logic             enter_clear;

    logic [CNT_W-1:0] mem [0:255];

    logic             s1_valid;
    logic [7:0]       s1_idx;
    logic             s2_valid;
    logic [7:0]       s2_idx;
    logic [CNT_W-1:0] s2_val;
    logic [CNT_W-1:0] base_val;
    logic [CNT_W-1:0] inc_val;
    logic             at_max;

    logic             sat_q;
    logic             missed_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_CLEAR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_acc   = 1'b0;
        case (state)
            S_CLEAR: if (clr_cnt == 8'hFF) state_nxt = S_IDLE;
            S_IDLE: begin
                // A pixel arriving with the opening pulse belongs to the frame.
                if (bus.frame_start) begin
                    state_nxt = S_ACCUM;
                    pix_acc   = bus.pix_valid;
                end
            end
            S_ACCUM: begin
                pix_acc = bus.pix_valid;
                if (bus.frame_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
            S_DONE:  if (bus.hist_clr) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign enter_clear    = (state == S_DONE) && bus.hist_clr;
    assign state_dbg      = state;
    assign bus.busy       = (state == S_CLEAR) || (state == S_DRAIN);
    assign bus.hist_ready = (state == S_DONE);
    assign bus.sat        = sat_q;
    assign bus.missed     = missed_q;

    // clr_cnt doubles as the clear write address; it wraps back to 0 as
    // CLEAR finishes so the next clear starts from bin 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt   <= 8'd0;
            drain_cnt <= 1'b0;
        end else begin
            clr_cnt   <= (state == S_CLEAR) ? clr_cnt + 8'd1 : 8'd0;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // ---------------- RMW pipeline ----------------
    // Stage 1 holds the bin index and reads the memory; stage 2 holds the
    // incremented count and writes it back. The only hazard is stage 2 not
    // yet having written the same bin stage 1 is reading, so that value is
    // forwarded. Older writes have already landed by the time of the read.
    always_comb begin
        base_val = mem[s1_idx];
        if (s2_valid && (s2_idx == s1_idx)) base_val = s2_val;
        at_max  = (base_val == CNT_MAX);
        inc_val = at_max ? base_val : base_val + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= 8'd0;
            s2_valid <= 1'b0;
            s2_idx   <= 8'd0;
            s2_val   <= '0;
        end else begin
            s1_valid <= pix_acc;
            s1_idx   <= bus.pix_in;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_val   <= inc_val;
        end
    end

    // Single write port: the pipeline is always empty while clearing.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)  mem[clr_cnt] <= '0;
        else if (s2_valid)     mem[s2_idx]  <= s2_val;
    end

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q    <= 1'b0;
            missed_q <= 1'b0;
        end else if (enter_clear) begin
            sat_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            if (s1_valid && at_max)                   sat_q    <= 1'b1;
            if (bus.frame_start && (state != S_IDLE)) missed_q <= 1'b1;
        end
    end

    // ---------------- read port ----------------
    // Reads sample the memory before any CLEAR write, so a read issued with
    // hist_clr still returns the finished count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en && (state == S_DONE);
            if (bus.rd_en && (state == S_DONE)) bus.rd_data <= mem[bus.rd_addr];
        end
    end

endmodule
